// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with valid/ready request and result ports.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    // A request moves on in_valid && in_ready; the result moves on out_valid && out_ready.
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mag_a, mag_b, fast_res;
    logic [2*WIDTH-1:0] acc;
    logic               neg_main, neg_rem, fast;

    logic               signed_a, signed_b, sa, sb, div_zero, ovf, fast_hit;
    logic [WIDTH-1:0]   abs_a, abs_b, fast_val, quo, rem, final_res;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    always_comb begin
        signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa       = signed_a && A[WIDTH-1];
        sb       = signed_b && B[WIDTH-1];
        abs_a    = sa ? ('0 - A) : A;
        abs_b    = sb ? ('0 - B) : B;
        div_zero = op[2] && (B == '0);
        ovf      = ((op == 3'b100) || (op == 3'b110)) &&
                   (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
        fast_hit = div_zero || ovf;
        if (div_zero) fast_val = op[1] ? A : '1;
        else          fast_val = op[1] ? '0 : A;
    end

    // Borrow out of the W+1-bit trial subtraction means the divisor did not fit.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_main ? ('0 - acc) : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                 final_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = neg_main ? ('0 - quo) : quo;
            default:                final_res = neg_rem ? ('0 - rem) : rem;
        endcase
        if (fast) final_res = fast_res;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    op_q     <= op;
                    mag_a    <= abs_a;
                    mag_b    <= abs_b;
                    neg_main <= sa ^ sb;
                    neg_rem  <= sa;
                    fast     <= fast_hit;
                    fast_res <= fast_val;
                    acc      <= op[2] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= fast_hit ? FIX : RUN;
                end
                RUN: begin
                    acc <= op_q[2] ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FIX;
                end
                FIX: begin
                    result    <= final_res;
                    zero      <= (final_res == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH 32 and WIDTH 8 with hand-computed results.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a32, b32;
    logic [2:0]  op;
    logic        iv32, iv8, or32, or8;
    logic        ir32, ov32, z32, ir8, ov8, z8;
    logic [31:0] r32;
    logic [7:0]  r8;
    logic        sel8;
    logic        cur_ir, cur_ov, cur_z;
    logic [31:0] cur_r;
    int          n_checks = 0;
    int          n_fail = 0;

    assign cur_ir = sel8 ? ir8 : ir32;
    assign cur_ov = sel8 ? ov8 : ov32;
    assign cur_z  = sel8 ? z8 : z32;
    assign cur_r  = sel8 ? {24'd0, r8} : r32;

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .op(op), .out_valid(ov32), .out_ready(or32),
        .result(r32), .zero(z32)
    );
    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(a32[7:0]), .B(b32[7:0]), .op(op), .out_valid(ov8), .out_ready(or8),
        .result(r8), .zero(z8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input string tag);
        int lat;
        sel8 = w8;
        @(negedge clk);
        check({tag, "_in_ready"}, cur_ir, 1);
        a32 = a; b32 = b; op = o;
        if (w8) iv8 = 1'b1; else iv32 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; iv32 = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, cur_r, exp);
        check({tag, "_zero"}, cur_z, exp == 0);
        if (w8) or8 = 1'b1; else or32 = 1'b1;
        @(negedge clk);
        or8 = 1'b0; or32 = 1'b0;
        check({tag, "_released"}, {cur_ov, cur_ir}, 2'b01);
    endtask

    initial begin
        int hits;
        rst_n = 1'b0; iv32 = 1'b0; iv8 = 1'b0; or32 = 1'b0; or8 = 1'b0;
        a32 = '0; b32 = '0; op = '0; sel8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst32", {ir32, ov32, z32, r32}, {3'b101, 32'd0});
        check("rst8", {ir8, ov8, z8, r8}, {3'b101, 8'd0});

        run_op(0, 3'b000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33, "mul");
        run_op(0, 3'b001, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, "mulh");
        run_op(0, 3'b011, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33, "mulhu");
        run_op(0, 3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(0, 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 33, "mul_shift");
        run_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_minmin");
        run_op(0, 3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, "div_neg");
        run_op(0, 3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, "rem_neg");
        run_op(0, 3'b101, 32'd7, 32'd2, 32'd3, 33, "divu");
        run_op(0, 3'b111, 32'd6, 32'd3, 32'd0, 33, "remu_zero");
        run_op(0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max");
        run_op(0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(0, 3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
        run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 9, "w8_mulhu");
        run_op(1, 3'b100, 32'h80, 32'hFF, 32'h80, 1, "w8_div_ovf");
        run_op(1, 3'b110, 32'hF9, 32'h2, 32'hFF, 9, "w8_rem_neg");

        // Backpressure: result held, new request ignored until the handshake.
        sel8 = 1'b0;
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd5; op = 3'b000; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        hits = 0;
        while (!ov32 && hits < 200) begin
            @(negedge clk);
            hits++;
        end
        check("bp_latency", hits, 33);
        for (int i = 0; i < 10; i++) begin
            a32 = 32'd100; b32 = 32'd7; op = 3'b101; iv32 = 1'b1;
            @(negedge clk);
            check("bp_hold", {ov32, ir32, r32}, {2'b10, 32'd15});
        end
        iv32 = 1'b0; or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        check("bp_release", {ov32, ir32}, 2'b01);

        // Reset in the middle of an iteration.
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd9; op = 3'b000; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (5) @(negedge clk);
        check("run_busy", ir32, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("run_rst", {ir32, ov32, z32, r32}, {3'b101, 32'd0});
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) hits++;
        end
        check("run_rst_no_valid", hits, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
